dmi_arbiter: RTL and testbench
==============================

DMI_ARBITER -- requirements
Module: dmi_arbiter

Interface
REQ-001 SHALL have parameter NumReq, default 2 (range 2..8): number of DMI requesters sharing one DM port.
REQ-002 SHALL have parameter TimeoutCycles, default 1024: response-timeout limit, used only with DMI_ARB_TIMEOUT_EN.
REQ-003 SHALL have port clk_i  in  1  single clock for all logic.
REQ-004 SHALL have port rst_ni  in  1  reset, synchronous, active-low.
REQ-005 SHALL have port req_i  in  NumReq x dm::dmi_req_t  per-requester request.
REQ-006 SHALL have port req_valid_i / req_ready_o  in / out  NumReq  per-requester request handshake.
REQ-007 SHALL have port resp_o  out  NumReq x dm::dmi_resp_t  per-requester response.
REQ-008 SHALL have port resp_valid_o / resp_ready_i  out / in  NumReq  per-requester response handshake.
REQ-009 SHALL have port dmi_req_o / dmi_req_valid_o / dmi_req_ready_i  out / out / in  dmi_req_t,1,1  downstream request.
REQ-010 SHALL have port dmi_resp_i / dmi_resp_valid_i / dmi_resp_ready_o  in / in / out  dmi_resp_t,1,1  downstream response.
REQ-011 SHALL have port busy_o  out  1  high whenever state is not Idle.

Function
REQ-012 SHALL implement FSM states Idle, Req, Resp, Flush (Flush only with DMI_ARB_TIMEOUT_EN).
REQ-013 Idle: SHALL grant the first valid requester at or after rr_ptr (round-robin), register index and request, move to Req next cycle; req_ready_o[grant] high in the grant cycle only.
REQ-014 Req: dmi_req_valid_o high, dmi_req_o = registered request (stable); on dmi_req_ready_i -> Resp.
REQ-015 Resp: dmi_resp_ready_o = resp_ready_i[grant]; resp_valid_o[grant] = dmi_resp_valid_i; resp_o[grant] = dmi_resp_i combinationally; on both valid and ready -> Idle.
REQ-016 Exactly one transaction outstanding; every request (read, write, nop) expects exactly one downstream response.
REQ-017 rr_ptr SHALL update to grant+1, wrapping NumReq-1 -> 0, on grant.
REQ-018 Non-granted requesters: req_ready_o=0, resp_valid_o=0, resp_o='0.
REQ-019 Downstream response while Idle or Req SHALL be accepted (dmi_resp_ready_o=1) and discarded.
REQ-020 Request issued to Idle to first dmi_req_valid_o: 1 cycle; no combinational path req_valid_i -> dmi_req_valid_o.
REQ-021 Requester deasserting req_valid_i after grant SHALL NOT abort the transaction.

Reset
REQ-022 rst_ni low at any clock edge SHALL force Idle, rr_ptr=0, grant=0, timeout counter=0; in-flight transaction dropped.
REQ-023 Reset values: req_ready_o=0, resp_valid_o=0, resp_o='0, dmi_req_valid_o=0, dmi_req_o='0, dmi_resp_ready_o=1 (Idle discard), busy_o=0.

Configuration
REQ-024 Macro DMI_ARB_TIMEOUT_EN defined: counter starts at 0 on entering Resp, increments per cycle; at TimeoutCycles-1 without response SHALL present resp_valid_o[grant] with resp=2'h2 (op failed), data=0; on acceptance -> Flush.
REQ-025 Flush: dmi_resp_ready_o=1, discard one downstream response or wait TimeoutCycles, then -> Idle.
REQ-026 Macro undefined: no counter, no Flush; Resp waits indefinitely.

Structure
REQ-027 dmi_req_t, dmi_resp_t and response codes SHALL come from package dm; arbiter state enum local.
REQ-028 Round-robin selection SHALL be sub-module dmi_rr_arb (inputs valid vector, ptr; outputs grant index, any-valid).

Verification
REQ-029 Single: req 0 read addr 0x11 -> dmi_req_valid_o 1 cycle later, op read; resp data 0xDEADBEEF routed only to requester 0.
REQ-030 Contention: req 0 and 1 valid continuously -> grants 0,1,0,1; rr_ptr wraps 1->0.
REQ-031 Backpressure: dmi_req_ready_i low 5 cycles, resp_ready_i[1] low 3 cycles -> dmi_req_o stable, resp held, no new grant.
REQ-032 Reset asserted in Resp -> next cycle Idle, all outputs at REQ-023 values, rr_ptr=0.
REQ-033 With DMI_ARB_TIMEOUT_EN, TimeoutCycles=16, no response -> resp=2'h2 at cycle 16; late response discarded in Flush; next request served normally.

Source files
------------

// File: rtl/dm_pkg.sv
// dm -- shared Debug Module Interface (DMI) types.
//
// Request/response structures and operation/response codes used by
// every block that talks DMI. Anything local to one block, such as an
// FSM state type, stays in that block.
package dm;

    localparam int unsigned DmiAddrW = 7;
    localparam int unsigned DmiDataW = 32;

    typedef enum logic [1:0] {
        DTM_NOP   = 2'h0,
        DTM_READ  = 2'h1,
        DTM_WRITE = 2'h2
    } dtm_op_e;

    // Response codes carried in dmi_resp_t.resp
    localparam logic [1:0] DTM_SUCCESS = 2'h0;
    localparam logic [1:0] DTM_ERR     = 2'h2;
    localparam logic [1:0] DTM_BUSY    = 2'h3;

    typedef struct packed {
        logic [DmiAddrW-1:0] addr;
        dtm_op_e             op;
        logic [DmiDataW-1:0] data;
    } dmi_req_t;

    typedef struct packed {
        logic [DmiDataW-1:0] data;
        logic [1:0]          resp;
    } dmi_resp_t;

endpackage

// File: rtl/dmi_rr_arb.sv
// dmi_rr_arb -- combinational round-robin picker.
//
// Returns the first asserted bit of valid_i at or after position ptr_i,
// wrapping from NumReq-1 back to 0.
//
// Ports:
//   valid_i  in  NumReq  request-valid vector
//   ptr_i    in  IdxW    highest-priority position this cycle
//   grant_o  out IdxW    index of the selected requester (0 when none)
//   valid_o  out 1       at least one requester is valid
module dmi_rr_arb #(
    parameter int unsigned NumReq = 2,
    parameter int unsigned IdxW   = $clog2(NumReq)
) (
    input  logic [NumReq-1:0] valid_i,
    input  logic [IdxW-1:0]   ptr_i,
    output logic [IdxW-1:0]   grant_o,
    output logic              valid_o
);

    logic [IdxW-1:0] idx;

    // NOTE: every output of a combinational block is given a default at the
    // top so that no path leaves it unassigned; otherwise a latch is inferred.
    always_comb begin
        grant_o = '0;
        valid_o = 1'b0;
        idx     = '0;
        // Walk from the farthest offset down to the nearest so that the
        // last hit (the one closest to ptr_i) wins.
        for (int i = int'(NumReq) - 1; i >= 0; i--) begin
            idx = IdxW'((int'(ptr_i) + i) % int'(NumReq));
            if (valid_i[idx]) begin
                grant_o = idx;
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dmi_arbiter.sv
// dmi_arbiter -- shares one downstream DMI port between NumReq requesters.
//
// A single transaction is outstanding at a time. In Idle the round-robin
// picker selects a requester; its request is registered and replayed
// downstream in Req, and the downstream response is routed back to that
// requester in Resp. Downstream responses that arrive while no response is
// expected are accepted and dropped.
//
// Optional feature, macro DMI_ARB_TIMEOUT_EN: if no response arrives within
// TimeoutCycles cycles of entering Resp, an error response (resp = DTM_ERR,
// data = 0) is returned to the requester and the FSM enters Flush, where it
// swallows one late downstream response or gives up after TimeoutCycles.
//
// Ports:
//   clk_i             in   1                clock
//   rst_ni            in   1                synchronous active-low reset
//   req_i             in   NumReq x req     per-requester request
//   req_valid_i       in   NumReq           request valid
//   req_ready_o       out  NumReq           request accepted (grant cycle)
//   resp_o            out  NumReq x resp    per-requester response
//   resp_valid_o      out  NumReq           response valid
//   resp_ready_i      in   NumReq           response accepted
//   dmi_req_o         out  req              downstream request
//   dmi_req_valid_o   out  1                downstream request valid
//   dmi_req_ready_i   in   1                downstream request accepted
//   dmi_resp_i        in   resp             downstream response
//   dmi_resp_valid_i  in   1                downstream response valid
//   dmi_resp_ready_o  out  1                downstream response accepted
//   busy_o            out  1                FSM not in Idle
module dmi_arbiter
    import dm::*;
#(
    parameter int unsigned NumReq        = 2,
    parameter int unsigned TimeoutCycles = 1024
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  dmi_req_t  [NumReq-1:0] req_i,
    input  logic      [NumReq-1:0] req_valid_i,
    output logic      [NumReq-1:0] req_ready_o,
    output dmi_resp_t [NumReq-1:0] resp_o,
    output logic      [NumReq-1:0] resp_valid_o,
    input  logic      [NumReq-1:0] resp_ready_i,
    output dmi_req_t               dmi_req_o,
    output logic                   dmi_req_valid_o,
    input  logic                   dmi_req_ready_i,
    input  dmi_resp_t              dmi_resp_i,
    input  logic                   dmi_resp_valid_i,
    output logic                   dmi_resp_ready_o,
    output logic                   busy_o
);

    localparam int unsigned IdxW = $clog2(NumReq);

    if (NumReq < 2 || NumReq > 8 || TimeoutCycles < 2) begin : g_param_check
        $error("dmi_arbiter: NumReq must be 2..8 and TimeoutCycles >= 2");
    end

    typedef enum logic [1:0] {
        Idle,
        Req,
        Resp
`ifdef DMI_ARB_TIMEOUT_EN
        ,
        Flush
`endif
    } state_e;

    state_e          state_q;
    logic [IdxW-1:0] grant_q;
    logic [IdxW-1:0] rr_ptr_q;
    dmi_req_t        req_q;
    logic            dmi_req_valid_q;
    logic            busy_q;

    logic [IdxW-1:0] arb_grant;
    logic            arb_valid;

`ifdef DMI_ARB_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TimeoutCycles);
    logic [CntW-1:0] cnt_q;
    logic            timed_out;

    // Saturation point: the counter stops advancing here, so the error
    // response stays stable until the requester takes it.
    assign timed_out = (state_q == Resp) && (cnt_q == CntW'(TimeoutCycles - 1));
`endif

    dmi_rr_arb #(
        .NumReq (NumReq),
        .IdxW   (IdxW)
    ) u_rr_arb (
        .valid_i (req_valid_i),
        .ptr_i   (rr_ptr_q),
        .grant_o (arb_grant),
        .valid_o (arb_valid)
    );

    // NOTE: state registers use non-blocking assignments only, so every
    // flop samples the pre-edge value of the others regardless of order.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q         <= Idle;
            grant_q         <= '0;
            rr_ptr_q        <= '0;
            req_q           <= '0;
            dmi_req_valid_q <= 1'b0;
            busy_q          <= 1'b0;
`ifdef DMI_ARB_TIMEOUT_EN
            cnt_q           <= '0;
`endif
        end else begin
            case (state_q)
                Idle: begin
                    if (arb_valid) begin
                        grant_q         <= arb_grant;
                        req_q           <= req_i[arb_grant];
                        rr_ptr_q        <= (arb_grant == IdxW'(NumReq - 1)) ?
                                           '0 : arb_grant + IdxW'(1);
                        dmi_req_valid_q <= 1'b1;
                        busy_q          <= 1'b1;
                        state_q         <= Req;
                    end
                end
                Req: begin
                    if (dmi_req_ready_i) begin
                        dmi_req_valid_q <= 1'b0;
                        state_q         <= Resp;
`ifdef DMI_ARB_TIMEOUT_EN
                        cnt_q           <= '0;
`endif
                    end
                end
                Resp: begin
`ifdef DMI_ARB_TIMEOUT_EN
                    if (timed_out) begin
                        if (resp_ready_i[grant_q]) begin
                            cnt_q   <= '0;
                            state_q <= Flush;
                        end
                    end else
`endif
                    if (dmi_resp_valid_i && resp_ready_i[grant_q]) begin
                        busy_q  <= 1'b0;
                        state_q <= Idle;
                    end
`ifdef DMI_ARB_TIMEOUT_EN
                    // A response that is present but stalled by the requester
                    // does not count toward the timeout.
                    else if (!dmi_resp_valid_i) begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
`endif
                end
`ifdef DMI_ARB_TIMEOUT_EN
                Flush: begin
                    if (dmi_resp_valid_i || cnt_q == CntW'(TimeoutCycles - 1)) begin
                        busy_q  <= 1'b0;
                        state_q <= Idle;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
`endif
                default: begin
                    busy_q          <= 1'b0;
                    dmi_req_valid_q <= 1'b0;
                    state_q         <= Idle;
                end
            endcase
        end
    end

    assign dmi_req_o       = req_q;
    assign dmi_req_valid_o = dmi_req_valid_q;
    assign busy_o          = busy_q;

    // Handshake steering. Outside Resp the downstream response port is
    // held ready so stray responses are drained instead of blocking.
    always_comb begin
        req_ready_o      = '0;
        resp_valid_o     = '0;
        resp_o           = '0;
        dmi_resp_ready_o = 1'b1;

        if (state_q == Idle && arb_valid) begin
            req_ready_o[arb_grant] = 1'b1;
        end

        if (state_q == Resp) begin
`ifdef DMI_ARB_TIMEOUT_EN
            if (timed_out) begin
                // Leave the late response pending; Flush will drop it.
                resp_valid_o[grant_q] = 1'b1;
                resp_o[grant_q]       = '{data: '0, resp: DTM_ERR};
                dmi_resp_ready_o      = 1'b0;
            end else
`endif
            begin
                resp_valid_o[grant_q] = dmi_resp_valid_i;
                resp_o[grant_q]       = dmi_resp_i;
                dmi_resp_ready_o      = resp_ready_i[grant_q];
            end
        end
    end

endmodule

// File: tb/tb_dmi_arbiter.sv
// tb_dmi_arbiter -- directed, table-driven bench for dmi_arbiter (NumReq=2,
// TimeoutCycles=16). The timeout sequence is compiled in when
// DMI_ARB_TIMEOUT_EN is defined; otherwise an indefinite-wait sequence runs.
module tb_dmi_arbiter;
    import dm::*;

    localparam int unsigned NumReq        = 2;
    localparam int unsigned TimeoutCycles = 16;

    logic                   clk_i = 1'b0;
    logic                   rst_ni;
    dmi_req_t  [NumReq-1:0] req_i;
    logic      [NumReq-1:0] req_valid_i;
    logic      [NumReq-1:0] req_ready_o;
    dmi_resp_t [NumReq-1:0] resp_o;
    logic      [NumReq-1:0] resp_valid_o;
    logic      [NumReq-1:0] resp_ready_i;
    dmi_req_t               dmi_req_o;
    logic                   dmi_req_valid_o;
    logic                   dmi_req_ready_i;
    dmi_resp_t              dmi_resp_i;
    logic                   dmi_resp_valid_i;
    logic                   dmi_resp_ready_o;
    logic                   busy_o;

    dmi_arbiter #(
        .NumReq        (NumReq),
        .TimeoutCycles (TimeoutCycles)
    ) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .req_i            (req_i),
        .req_valid_i      (req_valid_i),
        .req_ready_o      (req_ready_o),
        .resp_o           (resp_o),
        .resp_valid_o     (resp_valid_o),
        .resp_ready_i     (resp_ready_i),
        .dmi_req_o        (dmi_req_o),
        .dmi_req_valid_o  (dmi_req_valid_o),
        .dmi_req_ready_i  (dmi_req_ready_i),
        .dmi_resp_i       (dmi_resp_i),
        .dmi_resp_valid_i (dmi_resp_valid_i),
        .dmi_resp_ready_o (dmi_resp_ready_o),
        .busy_o           (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0]  mask;      // requesters asserting req_valid_i
        int          grant;     // expected winner
        dtm_op_e     op;
        logic [6:0]  addr;
        logic [31:0] wdata;
        logic [31:0] rdata;     // downstream response data
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Inputs change right after the falling edge; outputs are sampled 1ns later.
    task automatic tick();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    function automatic dmi_req_t mk_req(input dtm_op_e op, input logic [6:0] a, input logic [31:0] d);
        return '{addr: a, op: op, data: d};
    endfunction

    function automatic logic [1:0] onehot(input int g);
        logic [1:0] v;
        v    = '0;
        v[g] = 1'b1;
        return v;
    endfunction

    task automatic set_reqs(input dtm_op_e op, input logic [6:0] a, input logic [31:0] d);
        for (int r = 0; r < int'(NumReq); r++) begin
            req_i[r] = mk_req(op, a + 7'(r), d + 32'(r));
        end
    endtask

    // Full transaction from Idle back to Idle; requesters keep req_valid_i
    // asserted until the response phase to stress the no-new-grant rule.
    task automatic do_txn(input logic [1:0] mask, input int g, input dtm_op_e op,
                          input logic [6:0] a, input logic [31:0] wd, input logic [31:0] rd);
        dmi_resp_t exp_resp;
        set_reqs(op, a, wd);
        req_valid_i = mask;
        #1;
        check("grant_ready", 64'(req_ready_o), 64'(onehot(g)));
        check("no_comb_req_valid", 64'(dmi_req_valid_o), 64'(0));
        tick();
        #1;
        check("req_valid", 64'(dmi_req_valid_o), 64'(1));
        check("req_payload", 64'(dmi_req_o), 64'(mk_req(op, a + 7'(g), wd + 32'(g))));
        check("ready_low_in_req", 64'(req_ready_o), 64'(0));
        check("busy_in_req", 64'(busy_o), 64'(1));
        dmi_req_ready_i = 1'b1;
        tick();
        dmi_req_ready_i  = 1'b0;
        req_valid_i      = '0;
        exp_resp         = '{data: rd, resp: DTM_SUCCESS};
        dmi_resp_i       = exp_resp;
        dmi_resp_valid_i = 1'b1;
        resp_ready_i     = '1;
        #1;
        check("resp_valid_route", 64'(resp_valid_o), 64'(onehot(g)));
        check("resp_data", 64'(resp_o[g]), 64'(exp_resp));
        check("resp_other_zero", 64'(resp_o[1-g]), 64'(0));
        check("req_valid_off_in_resp", 64'(dmi_req_valid_o), 64'(0));
        tick();
        dmi_resp_valid_i = 1'b0;
        #1;
        check("idle_after_txn", 64'(busy_o), 64'(0));
    endtask

    initial begin
        dmi_req_t held;

        vecs[0] = '{2'b01, 0, DTM_READ,  7'h11, 32'h0000_0000, 32'hDEAD_BEEF};
        vecs[1] = '{2'b11, 1, DTM_READ,  7'h20, 32'h0000_0000, 32'h1111_2222};
        vecs[2] = '{2'b11, 0, DTM_WRITE, 7'h30, 32'hA5A5_0000, 32'h0000_0000};
        vecs[3] = '{2'b11, 1, DTM_READ,  7'h40, 32'h0000_0000, 32'h3333_4444};
        vecs[4] = '{2'b10, 1, DTM_WRITE, 7'h50, 32'h1234_5678, 32'h0000_0000};
        vecs[5] = '{2'b01, 0, DTM_WRITE, 7'h60, 32'h0BAD_F00D, 32'h0000_0000};
        vecs[6] = '{2'b01, 0, DTM_NOP,   7'h00, 32'h0000_0000, 32'h5555_6666};

        rst_ni           = 1'b0;
        req_i            = '0;
        req_valid_i      = '0;
        resp_ready_i     = '0;
        dmi_req_ready_i  = 1'b0;
        dmi_resp_i       = '0;
        dmi_resp_valid_i = 1'b0;
        @(negedge clk_i);
        tick();
        rst_ni = 1'b1;
        #1;
        check("rst_req_ready", 64'(req_ready_o), 64'(0));
        check("rst_resp_valid", 64'(resp_valid_o), 64'(0));
        check("rst_resp_o", 64'(resp_o), 64'(0));
        check("rst_dmi_req_valid", 64'(dmi_req_valid_o), 64'(0));
        check("rst_dmi_req", 64'(dmi_req_o), 64'(0));
        check("rst_dmi_resp_ready", 64'(dmi_resp_ready_o), 64'(1));
        check("rst_busy", 64'(busy_o), 64'(0));

        // Round-robin table: pointer 0 -> 1 -> 0 (wrap) -> 1 -> 0 ...
        for (int i = 0; i < 7; i++) begin
            do_txn(vecs[i].mask, vecs[i].grant, vecs[i].op, vecs[i].addr,
                   vecs[i].wdata, vecs[i].rdata);
        end

        // Backpressure: pointer is 1, both valid -> requester 1 wins.
        set_reqs(DTM_READ, 7'h70, 32'h0);
        req_valid_i = 2'b11;
        #1;
        check("bp_grant", 64'(req_ready_o), 64'(2'b10));
        tick();
        held             = mk_req(DTM_READ, 7'h71, 32'h1);
        dmi_resp_i       = '{data: 32'hBADB_AD00, resp: DTM_SUCCESS};
        dmi_resp_valid_i = 1'b1;   // stray response while in Req
        for (int c = 0; c < 5; c++) begin
            #1;
            check("bp_req_stable", 64'(dmi_req_o), 64'(held));
            check("bp_req_valid", 64'(dmi_req_valid_o), 64'(1));
            check("bp_no_new_grant", 64'(req_ready_o), 64'(0));
            check("bp_stray_discard_ready", 64'(dmi_resp_ready_o), 64'(1));
            check("bp_stray_not_routed", 64'(resp_valid_o), 64'(0));
            tick();
        end
        dmi_resp_valid_i = 1'b0;
        dmi_req_ready_i  = 1'b1;
        tick();
        dmi_req_ready_i  = 1'b0;
        dmi_resp_i       = '{data: 32'hCAFE_F00D, resp: DTM_SUCCESS};
        dmi_resp_valid_i = 1'b1;
        resp_ready_i     = 2'b01;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("bp_resp_valid_held", 64'(resp_valid_o), 64'(2'b10));
            check("bp_resp_data_held", 64'(resp_o[1]), 64'({32'hCAFE_F00D, DTM_SUCCESS}));
            check("bp_dmi_resp_stalled", 64'(dmi_resp_ready_o), 64'(0));
            check("bp_no_grant_in_resp", 64'(req_ready_o), 64'(0));
            tick();
        end
        resp_ready_i = 2'b11;
        #1;
        check("bp_resp_release", 64'(dmi_resp_ready_o), 64'(1));
        tick();
        dmi_resp_valid_i = 1'b0;
        #1;
        check("bp_next_grant_wraps", 64'(req_ready_o), 64'(2'b01));
        req_valid_i = '0;
        tick();

        // Requester withdraws req_valid_i right after grant: no abort.
        set_reqs(DTM_WRITE, 7'h0A, 32'h7777_0000);
        req_valid_i = 2'b01;
        #1;
        check("drop_grant", 64'(req_ready_o), 64'(2'b01));
        tick();
        req_valid_i = '0;
        tick();
        #1;
        check("drop_req_still_valid", 64'(dmi_req_valid_o), 64'(1));
        check("drop_req_payload", 64'(dmi_req_o), 64'(mk_req(DTM_WRITE, 7'h0A, 32'h7777_0000)));
        dmi_req_ready_i = 1'b1;
        tick();
        dmi_req_ready_i  = 1'b0;
        dmi_resp_i       = '{data: 32'h0, resp: DTM_SUCCESS};
        dmi_resp_valid_i = 1'b1;
        #1;
        check("drop_resp_routed", 64'(resp_valid_o), 64'(2'b01));
        tick();
        dmi_resp_valid_i = 1'b0;

        // Reset while in Resp (grant 0, pointer now 1).
        set_reqs(DTM_READ, 7'h3C, 32'h0);
        req_valid_i = 2'b01;
        tick();
        req_valid_i     = '0;
        dmi_req_ready_i = 1'b1;
        tick();
        dmi_req_ready_i  = 1'b0;
        dmi_resp_i       = '{data: 32'h9999_8888, resp: DTM_SUCCESS};
        dmi_resp_valid_i = 1'b1;
        resp_ready_i     = '0;
        #1;
        check("rstresp_in_resp", 64'(resp_valid_o), 64'(2'b01));
        rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1;
        #1;
        check("rstresp_busy", 64'(busy_o), 64'(0));
        check("rstresp_resp_valid", 64'(resp_valid_o), 64'(0));
        check("rstresp_resp_o", 64'(resp_o), 64'(0));
        check("rstresp_dmi_req", 64'(dmi_req_o), 64'(0));
        check("rstresp_dmi_req_valid", 64'(dmi_req_valid_o), 64'(0));
        check("rstresp_idle_discard", 64'(dmi_resp_ready_o), 64'(1));
        check("rstresp_req_ready", 64'(req_ready_o), 64'(0));
        dmi_resp_valid_i = 1'b0;
        resp_ready_i     = '1;
        // Pointer reset to 0: with both valid, requester 0 must win.
        do_txn(2'b11, 0, DTM_READ, 7'h12, 32'h0, 32'h4242_4242);

        // No downstream response: pointer is 1, only requester 0 asks.
        set_reqs(DTM_READ, 7'h55, 32'h0);
        req_valid_i = 2'b01;
        tick();
        req_valid_i     = '0;
        dmi_req_ready_i = 1'b1;
        tick();
        dmi_req_ready_i = 1'b0;
        resp_ready_i    = '1;
`ifdef DMI_ARB_TIMEOUT_EN
        for (int c = 1; c <= int'(TimeoutCycles); c++) begin
            #1;
            if (c < int'(TimeoutCycles)) begin
                check("to_waiting", 64'(resp_valid_o), 64'(0));
                tick();
            end else begin
                check("to_err_valid", 64'(resp_valid_o), 64'(2'b01));
                check("to_err_resp", 64'(resp_o[0]), 64'({32'h0, DTM_ERR}));
                check("to_err_hold_downstream", 64'(dmi_resp_ready_o), 64'(0));
            end
        end
        tick();
        dmi_resp_i       = '{data: 32'hDEAD_0001, resp: DTM_SUCCESS};
        dmi_resp_valid_i = 1'b1;
        #1;
        check("flush_busy", 64'(busy_o), 64'(1));
        check("flush_ready", 64'(dmi_resp_ready_o), 64'(1));
        check("flush_not_routed", 64'(resp_valid_o), 64'(0));
        tick();
        dmi_resp_valid_i = 1'b0;
        #1;
        check("flush_back_idle", 64'(busy_o), 64'(0));
`else
        for (int c = 0; c < 40; c++) begin
            tick();
        end
        #1;
        check("wait_no_resp", 64'(resp_valid_o), 64'(0));
        check("wait_still_busy", 64'(busy_o), 64'(1));
        dmi_resp_i       = '{data: 32'h600D_600D, resp: DTM_SUCCESS};
        dmi_resp_valid_i = 1'b1;
        #1;
        check("wait_late_resp", 64'(resp_o[0]), 64'({32'h600D_600D, DTM_SUCCESS}));
        tick();
        dmi_resp_valid_i = 1'b0;
`endif
        // Pointer is 1: requester 1 is served normally afterwards.
        do_txn(2'b11, 1, DTM_WRITE, 7'h66, 32'hFEED_0000, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
